// File: rtl/seq_div_7x2_if.sv
// Handshake bundle for the 7/2 sequential divider: operand side
// (in_valid/in_ready) and result side (out_valid/out_ready).
interface seq_div_7x2_if #(
  parameter int QW  = 5,
  parameter int DVW = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [QW+DVW-1:0] dividend;
  logic [DVW-1:0]    divisor;
  logic              out_valid;
  logic              out_ready;
  logic [QW-1:0]     quotient;
  logic [DVW-1:0]    remainder;
  logic              dbz;
  logic              ovf;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  // The divider itself
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/seq_div_7x2.sv
// Sequential restoring divider: splits a (QW+DVW)-bit dividend into a
// QW-bit quotient and DVW-bit remainder, one quotient bit per clock.
// Quotient overflow and divide-by-zero are flagged, never trapped.
module seq_div_7x2 #(
  parameter int QW  = 5,
  parameter int DVW = 2
) (
  input  logic         clk,
  input  logic         rst,
  seq_div_7x2_if.slave bus
);

  localparam int DW = QW + DVW;
  localparam int CW = $clog2(QW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [DVW-1:0] part_r;
  logic [DVW-1:0] dvs;
  logic [QW-1:0]  lo_bits;
  logic [QW-1:0]  quot;
  logic [DVW-1:0] rem;
  logic           dbz_r;
  logic           ovf_r;

  logic [DVW-1:0] hi;
  logic [DVW:0]   t;
  logic           t_ge;
  logic [DVW-1:0] r_nxt;

  // Exception test on the incoming operands and one restoring step on
  // the held partial remainder; the step result always fits DVW bits
  // because it is strictly below the divisor.
  always_comb begin
    hi    = bus.dividend[DW-1:QW];
    t     = {part_r, lo_bits[QW-1]};
    t_ge  = (t >= {1'b0, dvs});
    r_nxt = t_ge ? DVW'(t - {1'b0, dvs}) : t[DVW-1:0];
  end

  // Control and result registers. An exception spends one cycle in BUSY
  // (ovf already set) so its result appears one edge after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      part_r  <= '0;
      dvs     <= '0;
      lo_bits <= '0;
      quot    <= '0;
      rem     <= '0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvs     <= bus.divisor;
            lo_bits <= bus.dividend[QW-1:0];
            rem     <= '0;
            state   <= BUSY;
            if (hi >= bus.divisor) begin
              quot   <= '1;
              ovf_r  <= 1'b1;
              dbz_r  <= (bus.divisor == '0);
              part_r <= '0;
              cnt    <= '0;
            end else begin
              quot   <= '0;
              ovf_r  <= 1'b0;
              dbz_r  <= 1'b0;
              part_r <= hi;
              cnt    <= CW'(QW);
            end
          end
        end
        BUSY: begin
          if (ovf_r) begin
            state <= DONE;
          end else begin
            part_r  <= r_nxt;
            quot    <= {quot[QW-2:0], t_ge};
            lo_bits <= lo_bits << 1;
            cnt     <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              rem   <= r_nxt;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and result outputs
  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == DONE);
    bus.quotient  = quot;
    bus.remainder = rem;
    bus.dbz       = dbz_r;
    bus.ovf       = ovf_r;
  end

endmodule

// File: tb/tb_seq_div_7x2.sv
// Bench for seq_div_7x2: directed cases, back-pressure, reset abort,
// back-to-back issue and an exhaustive sweep against an arithmetic model.
module tb_seq_div_7x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  seq_div_7x2_if #(.QW(5), .DVW(2)) bus ();

  seq_div_7x2 #(.QW(5), .DVW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the quotient-fit rule
  function automatic void ref_div(input int dvd, input int dvs,
                                  output int q, output int r,
                                  output bit z, output bit o);
    z = (dvs == 0);
    if (dvs == 0 || (dvd / dvs) > 31) begin
      q = 31; r = 0; o = 1'b1;
    end else begin
      q = dvd / dvs; r = dvd % dvs; o = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents operands for one edge
  task automatic issue(input int dvd, input int dvs);
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    bus.dividend = 7'(dvd);
    bus.divisor  = 2'(dvs);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid; -1 on timeout
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    n_cmp++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.dbz, bus.ovf} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b q=%0d r=%0d dbz=%b ovf=%b want all 0",
               bus.out_valid, bus.quotient, bus.remainder, bus.dbz, bus.ovf);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_normal();
    int dvds[5] = '{90, 94, 7, 50, 31};
    int dvss[5] = '{3, 3, 2, 2, 1};
    int q, r, lat;
    bit z, o;
    for (int i = 0; i < 5; i++) begin
      ref_div(dvds[i], dvss[i], q, r, z, o);
      issue(dvds[i], dvss[i]);
      wait_valid(lat);
      n_cmp++;
      if (lat !== 5) begin
        n_fail++; $display("FAIL normal_latency %0d/%0d: got %0d want 5", dvds[i], dvss[i], lat);
      end
      n_cmp++;
      if ({bus.quotient, bus.remainder, bus.dbz, bus.ovf} !== {5'(q), 2'(r), z, o}) begin
        n_fail++;
        $display("FAIL normal_result %0d/%0d: got q=%0d r=%0d dbz=%b ovf=%b want q=%0d r=%0d dbz=%b ovf=%b",
                 dvds[i], dvss[i], bus.quotient, bus.remainder, bus.dbz, bus.ovf, q, r, z, o);
      end
      consume();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        n_fail++; $display("FAIL normal_release: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_exception();
    int dvds[4] = '{64, 0, 127, 37};
    int dvss[4] = '{2, 0, 1, 0};
    int q, r, lat;
    bit z, o;
    for (int i = 0; i < 4; i++) begin
      ref_div(dvds[i], dvss[i], q, r, z, o);
      issue(dvds[i], dvss[i]);
      wait_valid(lat);
      n_cmp++;
      if (lat !== 1) begin
        n_fail++; $display("FAIL exc_latency %0d/%0d: got %0d want 1", dvds[i], dvss[i], lat);
      end
      n_cmp++;
      if ({bus.quotient, bus.remainder, bus.dbz, bus.ovf} !== {5'(q), 2'(r), z, o}) begin
        n_fail++;
        $display("FAIL exc_result %0d/%0d: got q=%0d r=%0d dbz=%b ovf=%b want q=%0d r=%0d dbz=%b ovf=%b",
                 dvds[i], dvss[i], bus.quotient, bus.remainder, bus.dbz, bus.ovf, q, r, z, o);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(94, 3);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.dividend = 7'($urandom_range(0, 127));
      bus.divisor  = 2'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.dbz, bus.ovf} !==
          {1'b1, 1'b0, 5'd31, 2'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: got v=%b rdy=%b q=%0d r=%0d dbz=%b ovf=%b want v=1 rdy=0 q=31 r=1 dbz=0 ovf=0",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.dbz, bus.ovf);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !== {1'b0, 1'b1, 5'd31, 2'd1}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b rdy=%b q=%0d r=%0d want v=0 rdy=1 q=31 r=1",
               bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(90, 3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.dbz, bus.ovf} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b rdy=%b q=%0d r=%0d dbz=%b ovf=%b want all 0",
               bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.dbz, bus.ovf);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_idle: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_no_emit cyc %0d: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
    issue(93, 3);
    wait_valid(lat);
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.dbz, bus.ovf} !== {5'd31, 2'd0, 1'b0, 1'b0} || lat !== 5) begin
      n_fail++;
      $display("FAIL midreset_next: got q=%0d r=%0d dbz=%b ovf=%b lat=%0d want q=31 r=0 dbz=0 ovf=0 lat=5",
               bus.quotient, bus.remainder, bus.dbz, bus.ovf, lat);
    end
    consume();
  endtask

  task automatic test_simultaneous();
    int lat;
    issue(7, 2);
    wait_valid(lat);
    bus.dividend  = 7'd90;
    bus.divisor   = 2'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL simul_no_accept: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    n_cmp++;
    if ({bus.quotient, bus.remainder} !== {5'd30, 2'd0} || lat !== 5) begin
      n_fail++;
      $display("FAIL simul_next: got q=%0d r=%0d lat=%0d want q=30 r=0 lat=5", bus.quotient, bus.remainder, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] got, want;
    int cyc = 0, last = -1, nops = 0, dvd, dvs, q, r;
    bit z, o, prev_exc = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    while ((nops < 8 || exp_q.size() > 0) && cyc < 200) begin
      if (bus.out_valid) begin
        got = {bus.quotient, bus.remainder, bus.dbz, bus.ovf};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got result %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL b2b_result: got %h want %h", got, want);
          end
        end
      end
      if (bus.in_ready) begin
        if (nops < 8) begin
          dvd = $urandom_range(0, 127);
          dvs = $urandom_range(0, 3);
          bus.dividend = 7'(dvd);
          bus.divisor  = 2'(dvs);
          ref_div(dvd, dvs, q, r, z, o);
          exp_q.push_back({5'(q), 2'(r), z, o});
          if (last >= 0) begin
            n_cmp++;
            if (cyc - last !== (prev_exc ? 3 : 7)) begin
              n_fail++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last, prev_exc ? 3 : 7);
            end
          end
          last = cyc;
          prev_exc = o;
          nops++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 200) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d cycles want < 200", cyc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_exhaustive();
    int q, r, lat;
    bit z, o, exc_rule;
    for (int dvd = 0; dvd < 128; dvd++) begin
      for (int dvs = 0; dvs < 4; dvs++) begin
        ref_div(dvd, dvs, q, r, z, o);
        exc_rule = ((dvd >> 5) >= dvs);
        issue(dvd, dvs);
        wait_valid(lat);
        n_cmp++;
        if (lat !== (exc_rule ? 1 : 5) ||
            {bus.dbz, bus.ovf} !== {dvs == 0, exc_rule}) begin
          n_fail++;
          $display("FAIL exh_flags %0d/%0d: got lat=%0d dbz=%b ovf=%b want lat=%0d dbz=%b ovf=%b",
                   dvd, dvs, lat, bus.dbz, bus.ovf, exc_rule ? 1 : 5, dvs == 0, exc_rule);
        end
        n_cmp++;
        if ({bus.quotient, bus.remainder} !== {5'(q), 2'(r)}) begin
          n_fail++;
          $display("FAIL exh_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                   dvd, dvs, bus.quotient, bus.remainder, q, r);
        end
        if (!exc_rule) begin
          n_cmp++;
          if (int'(bus.quotient) * dvs + int'(bus.remainder) != dvd || int'(bus.remainder) >= dvs) begin
            n_fail++;
            $display("FAIL exh_invariant %0d/%0d: got q=%0d r=%0d want q*d+r=%0d and r<d",
                     dvd, dvs, bus.quotient, bus.remainder, dvd);
          end
        end
        repeat ($urandom_range(0, 3)) tick();
        consume();
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    test_reset();
    test_normal();
    test_exception();
    test_backpressure();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
